// File: rtl/cpu_mon_pkg.sv
// Shared types and constants for the CPU run-control / performance-monitor block.
// Run-state encoding and fixed counter-bank slot indices.
package cpu_mon_pkg;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_PAUSE  = 3'd1,
      ST_HALT   = 3'd2,
      ST_STEP   = 3'd3,
      ST_RESUME = 3'd4
   } run_state_t;

   localparam int CNT_CYC = 0;
   localparam int CNT_RET = 1;
   localparam int CNT_EV0 = 2;

endpackage

// File: rtl/mon_counter.sv
// Single performance counter with synchronous clear and a sticky overflow flag.
// Reaching all-ones either wraps to zero or sticks, depending on SATURATE.
module mon_counter #(
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] value,
   output logic             ovf
);

   logic [CNT_W-1:0] value_reg;
   logic             ovf_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_reg <= '0;
         ovf_reg   <= 1'b0;
      end else if (clr) begin
         value_reg <= '0;
         ovf_reg   <= 1'b0;
      end else if (en) begin
         if (&value_reg) begin
            ovf_reg <= 1'b1;
            if (!SATURATE)
               value_reg <= '0;
         end else begin
            value_reg <= value_reg + 1'b1;
         end
      end
   end

   assign value = value_reg;
   assign ovf   = ovf_reg;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run/pause/halt/step control of the core's PC-advance enable, plus a counter
// bank (cycles, retirements, per-event counts) behind a registered read port.
module cpu_run_monitor
   import cpu_mon_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int NUM_EV   = 2,
   parameter bit SATURATE = 1'b0,
   parameter int SEL_W    = $clog2(NUM_EV + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pause,
   input  logic              step,
   input  logic              halt_req,
   input  logic [NUM_EV-1:0] ev,
   input  logic              clr,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic              pc_enable,
   output logic [2:0]        run_state,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_ovf
);

   localparam int NUM_CNT = NUM_EV + 2;

   run_state_t       state_reg;
   logic             pause_q_reg;
   logic             pe;
   logic [NUM_CNT-1:0] cnt_en;
   logic [NUM_CNT-1:0] cnt_ovf;
   logic [CNT_W-1:0] cnt_value [NUM_CNT];
   logic [CNT_W-1:0] rd_data_reg, rd_data_next;
   logic             rd_ovf_reg, rd_ovf_next;

   // Only the press edge counts, so a held button toggles the state once.
   assign pe = pause & ~pause_q_reg;

   // STEP and RESUME retire one instruction even with halt_req high.
   assign pc_enable = ((state_reg == ST_RUN) && !halt_req) ||
                      (state_reg == ST_STEP) || (state_reg == ST_RESUME);
   assign run_state = state_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_RUN;
         pause_q_reg <= 1'b0;
      end else begin
         pause_q_reg <= pause;
         case (state_reg)
            ST_RUN: begin
               if (pe)            state_reg <= ST_PAUSE;
               else if (halt_req) state_reg <= ST_HALT;
            end
            ST_PAUSE: begin
               if (pe)            state_reg <= ST_RUN;
               else if (step)     state_reg <= ST_STEP;
            end
            ST_HALT: begin
               if (pe)            state_reg <= ST_RESUME;
            end
            ST_STEP:              state_reg <= ST_PAUSE;
            ST_RESUME:            state_reg <= ST_RUN;
            default:              state_reg <= ST_RUN;
         endcase
      end
   end

   assign cnt_en[CNT_CYC] = 1'b1;
   assign cnt_en[CNT_RET] = pc_enable;

   generate
      for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_ev_en
         assign cnt_en[CNT_EV0 + gi] = ev[gi] & pc_enable;
      end

      for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         mon_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
         ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en    (cnt_en[gi]),
            .clr   (clr),
            .value (cnt_value[gi]),
            .ovf   (cnt_ovf[gi])
         );
      end
   endgenerate

   // Out-of-range selects fall through to zero.
   always_comb begin
      rd_data_next = '0;
      rd_ovf_next  = 1'b0;
      for (int k = 0; k < NUM_CNT; k++) begin
         if (int'(rd_sel) == k) begin
            rd_data_next = cnt_value[k];
            rd_ovf_next  = cnt_ovf[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_reg <= '0;
         rd_ovf_reg  <= 1'b0;
      end else begin
         rd_data_reg <= rd_data_next;
         rd_ovf_reg  <= rd_ovf_next;
      end
   end

   assign rd_data = rd_data_reg;
   assign rd_ovf  = rd_ovf_reg;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: a 32-bit wrapping instance plus two
// 4-bit instances (wrapping and saturating) driven by the same stimulus.
module tb_cpu_run_monitor;
   import cpu_mon_pkg::*;

   logic       clk = 1'b0;
   logic       rst, pause, step, halt_req, clr;
   logic [1:0] ev;
   logic [2:0] rd_sel;

   logic        pc_enable_m, pc_enable_w, pc_enable_s;
   logic [2:0]  run_state_m, run_state_w, run_state_s;
   logic [31:0] rd_data_m;
   logic [3:0]  rd_data_w, rd_data_s;
   logic        rd_ovf_m, rd_ovf_w, rd_ovf_s;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      int          dut;
      logic [31:0] data;
      logic        ovf;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   cpu_run_monitor #(.CNT_W(32), .NUM_EV(2), .SATURATE(1'b0), .SEL_W(3)) u_main (
      .clk(clk), .rst(rst), .pause(pause), .step(step), .halt_req(halt_req),
      .ev(ev), .clr(clr), .rd_sel(rd_sel), .pc_enable(pc_enable_m),
      .run_state(run_state_m), .rd_data(rd_data_m), .rd_ovf(rd_ovf_m));

   cpu_run_monitor #(.CNT_W(4), .NUM_EV(2), .SATURATE(1'b0), .SEL_W(3)) u_wrap (
      .clk(clk), .rst(rst), .pause(pause), .step(step), .halt_req(halt_req),
      .ev(ev), .clr(clr), .rd_sel(rd_sel), .pc_enable(pc_enable_w),
      .run_state(run_state_w), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w));

   cpu_run_monitor #(.CNT_W(4), .NUM_EV(2), .SATURATE(1'b1), .SEL_W(3)) u_sat (
      .clk(clk), .rst(rst), .pause(pause), .step(step), .halt_req(halt_req),
      .ev(ev), .clr(clr), .rd_sel(rd_sel), .pc_enable(pc_enable_s),
      .run_state(run_state_s), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s));

   // Current read-port output of the selected instance as {ovf, data}.
   function automatic logic [32:0] rd_of(int d);
      case (d)
         1:       return {rd_ovf_w, 28'd0, rd_data_w};
         2:       return {rd_ovf_s, 28'd0, rd_data_s};
         default: return {rd_ovf_m, rd_data_m};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pause = 1'b0; step = 1'b0; halt_req = 1'b0;
      ev = 2'b00; clr = 1'b0; rd_sel = 3'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [32:0] act;
      rst = 1'b1; pause = 1'b0; step = 1'b0; halt_req = 1'b1;
      ev = 2'b00; clr = 1'b0; rd_sel = 3'd0;
      #2;
      n_checks++;
      if (run_state_m !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", run_state_m); end
      n_checks++;
      if (pc_enable_m !== 1'b0) begin n_fail++; $display("FAIL reset_pcen_halt: got %b expected 0", pc_enable_m); end
      n_checks++;
      if ({rd_ovf_m, rd_data_m} !== 33'd0) begin n_fail++; $display("FAIL reset_rd: got %0d/%b expected 0/0", rd_data_m, rd_ovf_m); end
      halt_req = 1'b0;
      #1;
      n_checks++;
      if (pc_enable_m !== 1'b1) begin n_fail++; $display("FAIL reset_pcen: got %b expected 1", pc_enable_m); end
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (pc_enable_m !== 1'b1 || run_state_m !== ST_RUN) begin
            n_fail++; $display("FAIL run_cycle%0d: got pcen=%b state=%0d expected 1/0", i, pc_enable_m, run_state_m);
         end
      end
      rd_sel = 3'd0;
      sb.push_back('{"cyc_after_10", 0, 32'd10, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      rd_sel = 3'd1;
      sb.push_back('{"ret_after_11", 0, 32'd11, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
   endtask

   task automatic test_halt();
      exp_t        e;
      logic [32:0] act;
      do_reset();
      tick();
      tick();
      halt_req = 1'b1;
      #1;
      n_checks++;
      if (pc_enable_m !== 1'b0) begin n_fail++; $display("FAIL halt_pcen_same: got %b expected 0", pc_enable_m); end
      tick();
      n_checks++;
      if (run_state_m !== ST_HALT) begin n_fail++; $display("FAIL halt_state: got %0d expected 2", run_state_m); end
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
      n_checks++;
      if (run_state_m !== ST_HALT || pc_enable_m !== 1'b0) begin
         n_fail++; $display("FAIL halt_hold: got state=%0d pcen=%b expected 2/0", run_state_m, pc_enable_m);
      end
      rd_sel = 3'd1;
      sb.push_back('{"ret_frozen", 0, 32'd2, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      pause = 1'b1;
      tick();
      pause = 1'b0;
      n_checks++;
      if (run_state_m !== ST_RESUME || pc_enable_m !== 1'b1) begin
         n_fail++; $display("FAIL resume: got state=%0d pcen=%b expected 4/1", run_state_m, pc_enable_m);
      end
      tick();
      n_checks++;
      if (run_state_m !== ST_RUN || pc_enable_m !== 1'b0) begin
         n_fail++; $display("FAIL after_resume: got state=%0d pcen=%b expected 0/0", run_state_m, pc_enable_m);
      end
      halt_req = 1'b0;
      #1;
      n_checks++;
      if (pc_enable_m !== 1'b1) begin n_fail++; $display("FAIL halt_drop_pcen: got %b expected 1", pc_enable_m); end
      sb.push_back('{"ret_after_resume", 0, 32'd3, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      repeat (4) tick();
      sb.push_back('{"ret_counting", 0, 32'd8, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
   endtask

   task automatic test_pause_step();
      exp_t        e;
      logic [32:0] act;
      logic [2:0]  prev;
      int          trans;
      do_reset();
      tick();
      pause = 1'b1; halt_req = 1'b1;
      #1;
      n_checks++;
      if (pc_enable_m !== 1'b0) begin n_fail++; $display("FAIL pe_halt_pcen: got %b expected 0", pc_enable_m); end
      tick();
      pause = 1'b0; halt_req = 1'b0;
      n_checks++;
      if (run_state_m !== ST_PAUSE) begin n_fail++; $display("FAIL pe_priority: got %0d expected 1", run_state_m); end
      rd_sel = 3'd1;
      sb.push_back('{"ret_before_step", 0, 32'd1, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      for (int s = 0; s < 3; s++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         n_checks++;
         if (run_state_m !== ST_STEP || pc_enable_m !== 1'b1) begin
            n_fail++; $display("FAIL step%0d_state: got %0d/%b expected 3/1", s, run_state_m, pc_enable_m);
         end
         tick();
         n_checks++;
         if (run_state_m !== ST_PAUSE || pc_enable_m !== 1'b0) begin
            n_fail++; $display("FAIL step%0d_back: got %0d/%b expected 1/0", s, run_state_m, pc_enable_m);
         end
         tick();
         tick();
      end
      sb.push_back('{"ret_after_steps", 0, 32'd4, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      pause = 1'b1;
      prev = run_state_m;
      trans = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (run_state_m !== prev) trans++;
         prev = run_state_m;
      end
      pause = 1'b0;
      n_checks++;
      if (trans != 1 || run_state_m !== ST_RUN) begin
         n_fail++; $display("FAIL held_pause: got %0d transitions state=%0d expected 1/0", trans, run_state_m);
      end
   endtask

   task automatic test_overflow();
      exp_t        e;
      logic [32:0] act;
      do_reset();
      repeat (17) tick();
      rd_sel = 3'd1;
      sb.push_back('{"wrap_ret", 1, 32'd1, 1'b1});
      sb.push_back('{"sat_ret", 2, 32'd15, 1'b1});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      sb.push_back('{"wrap_clr", 1, 32'd0, 1'b0});
      sb.push_back('{"sat_clr", 2, 32'd0, 1'b0});
      sb.push_back('{"main_clr", 0, 32'd0, 1'b0});
      tick();
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
   endtask

   task automatic test_events();
      exp_t        e;
      logic [32:0] act;
      logic [2:0]  sels [4];
      logic [31:0] exps [4];
      sels = '{3'd3, 3'd2, 3'd7, 3'd4};
      exps = '{32'd0, 32'd5, 32'd0, 32'd0};
      do_reset();
      ev = 2'b01;
      repeat (5) tick();
      ev = 2'b00;
      pause = 1'b1;
      tick();
      pause = 1'b0;
      ev = 2'b01;
      tick();
      tick();
      ev = 2'b00;
      n_checks++;
      if (run_state_m !== ST_PAUSE) begin n_fail++; $display("FAIL ev_paused: got %0d expected 1", run_state_m); end
      for (int k = 0; k < 4; k++) begin
         rd_sel = sels[k];
         sb.push_back('{$sformatf("ev_sel%0d", sels[k]), 0, exps[k], 1'b0});
         tick();
         while (sb.size() > 0) begin
            e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
            if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
            else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
         end
      end
   endtask

   task automatic test_reset_mid_step();
      exp_t        e;
      logic [32:0] act;
      logic [2:0]  prev;
      int          trans;
      do_reset();
      rd_sel = 3'd1;
      repeat (3) tick();
      pause = 1'b1;
      tick();
      pause = 1'b0;
      step = 1'b1;
      tick();
      step = 1'b0;
      n_checks++;
      if (run_state_m !== ST_STEP || rd_data_m === 32'd0) begin
         n_fail++; $display("FAIL pre_rst_step: got state=%0d rd=%0d expected 3/nonzero", run_state_m, rd_data_m);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (run_state_m !== ST_RUN || pc_enable_m !== 1'b1 || rd_data_m !== 32'd0 || rd_ovf_m !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: got state=%0d pcen=%b rd=%0d/%b expected 0/1/0/0", run_state_m, pc_enable_m, rd_data_m, rd_ovf_m);
      end
      tick();
      rst = 1'b0;
      sb.push_back('{"ret_post_rst", 0, 32'd0, 1'b0});
      tick();
      n_checks++;
      if (run_state_m !== ST_RUN) begin n_fail++; $display("FAIL no_pending_step: got %0d expected 0", run_state_m); end
      while (sb.size() > 0) begin
         e = sb.pop_front(); act = rd_of(e.dut); n_checks++;
         if (act !== {e.ovf, e.data}) begin n_fail++; $display("FAIL %s: got %0d/%b expected %0d/%b", e.name, act[31:0], act[32], e.data, e.ovf); end
         else $display("read %s = %0d/%b", e.name, act[31:0], act[32]);
      end
      pause = 1'b1;
      prev = run_state_m;
      trans = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (run_state_m !== prev) trans++;
         prev = run_state_m;
      end
      pause = 1'b0;
      n_checks++;
      if (trans != 1 || run_state_m !== ST_PAUSE) begin
         n_fail++; $display("FAIL post_rst_pe: got %0d transitions state=%0d expected 1/1", trans, run_state_m);
      end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_pause_step();
      test_overflow();
      test_events();
      test_reset_mid_step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
